// File: rtl/dict_lookup_sequencer_pkg.sv
// Shared constants and FSM encoding for the dictionary lookup sequencer.
// Word-list entries are 4 big-endian bytes whose low 25 bits hold five 5-bit letter codes.
package dict_lookup_sequencer_pkg;

    localparam int LETTER_W     = 5;
    localparam int WORD_LETTERS = 5;
    localparam int KEY_W        = LETTER_W * WORD_LETTERS;
    localparam int ENTRY_BYTES  = 4;

    typedef logic [2:0] lookup_state_t;

    localparam lookup_state_t IDLE  = 3'd0;
    localparam lookup_state_t PROBE = 3'd1;
    localparam lookup_state_t REQ   = 3'd2;
    localparam lookup_state_t RECV  = 3'd3;
    localparam lookup_state_t CMP   = 3'd4;
    localparam lookup_state_t DONE  = 3'd5;

endpackage

// File: rtl/dict_lookup_sequencer_if.sv
// Game-side request/result signals plus the word-list fetch channel toward the QSPI arbiter.
// master = the sequencer, slave = game logic / arbiter side.
interface dict_lookup_sequencer_if;
    import dict_lookup_sequencer_pkg::*;

    logic             start;
    logic [KEY_W-1:0] guess;
    logic             busy;
    logic             done;
    logic             found;
    logic             timeout_err;
    logic             fetch;
    logic [23:0]      fetch_addr;
    logic             fetch_grant;
    logic [7:0]       rd_data;
    logic             rd_valid;

    modport master (
        input  start, guess, fetch_grant, rd_data, rd_valid,
        output busy, done, found, timeout_err, fetch, fetch_addr
    );

    modport slave (
        output start, guess, fetch_grant, rd_data, rd_valid,
        input  busy, done, found, timeout_err, fetch, fetch_addr
    );

endinterface

// File: rtl/dict_lookup_sequencer_qspi_word_assembler.sv
// Collects QSPI bytes MSB-first into one word-list entry; full rises the cycle after the 4th byte.
// No backpressure: the caller gates shift, and further shifts are ignored once full.
module qspi_word_assembler
    import dict_lookup_sequencer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       shift,
    input  logic [7:0]                 byte_in,
    output logic [8*ENTRY_BYTES-1:0]   word,
    output logic                       full
);

    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            full <= 1'b0;
        end else if (shift && !full) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
        end else if (shift && !full) begin
            word <= {word[8*ENTRY_BYTES-9:0], byte_in};
        end
    end

endmodule

// File: rtl/dict_lookup_sequencer.sv
// Binary search of a 5-letter guess in the flash word list; per probe 2 FSM cycles + grant wait + 4 bytes.
// Holds fetch until granted and never stalls rd_valid; LOOKUP_TIMEOUT_EN adds a per-probe abort.
module dict_lookup_sequencer
    import dict_lookup_sequencer_pkg::*;
#(
    parameter logic [23:0] WORDLIST_BASE = 24'h010000,
    parameter int          WORD_COUNT    = 2315
`ifdef LOOKUP_TIMEOUT_EN
    ,
    parameter int          TIMEOUT       = 4095
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    dict_lookup_sequencer_if.master  bus
);

    localparam int IDX_W = $clog2(WORD_COUNT + 1);

    lookup_state_t              state;
    logic [IDX_W-1:0]           lo;
    logic [IDX_W-1:0]           hi;
    logic [IDX_W-1:0]           mid;
    logic [IDX_W-1:0]           mid_c;
    logic [KEY_W-1:0]           guess_q;
    logic [KEY_W-1:0]           entry_key;
    logic                       found_q;
    logic                       fetch_q;
    logic [23:0]                fetch_addr_q;
    logic                       asm_clear;
    logic                       asm_shift;
    logic                       asm_full;
    logic [8*ENTRY_BYTES-1:0]   asm_word;
    logic                       unused_entry_pad;

    // Sum taken one bit wider so lo+hi cannot wrap before halving.
    assign mid_c            = IDX_W'(({1'b0, lo} + {1'b0, hi}) >> 1);
    assign entry_key        = asm_word[KEY_W-1:0];
    assign unused_entry_pad = ^asm_word[8*ENTRY_BYTES-1:KEY_W];
    assign asm_clear        = (state == REQ) && bus.fetch_grant;
    assign asm_shift        = (state == RECV) && bus.rd_valid && !asm_full;

    assign bus.busy       = (state != IDLE) && (state != DONE);
    assign bus.done       = (state == DONE);
    assign bus.found      = found_q;
    assign bus.fetch      = fetch_q;
    assign bus.fetch_addr = fetch_addr_q;

    qspi_word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .shift   (asm_shift),
        .byte_in (bus.rd_data),
        .word    (asm_word),
        .full    (asm_full)
    );

`ifdef LOOKUP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             tmo_err_q;

    assign tmo_hit         = ((state == REQ) || (state == RECV)) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign bus.timeout_err = tmo_err_q;

    // Counts only while waiting on the arbiter or flash; every byte arrival restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state == REQ) || (state == RECV)) begin
            tmo_cnt <= bus.rd_valid ? '0 : tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_err_q <= 1'b0;
        end else if ((state == IDLE) && bus.start) begin
            tmo_err_q <= 1'b0;
        end else if (tmo_hit) begin
            tmo_err_q <= 1'b1;
        end
    end
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lo           <= '0;
            hi           <= '0;
            mid          <= '0;
            guess_q      <= '0;
            found_q      <= 1'b0;
            fetch_q      <= 1'b0;
            fetch_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        guess_q <= bus.guess;
                        lo      <= '0;
                        hi      <= IDX_W'(WORD_COUNT);
                        found_q <= 1'b0;
                        state   <= PROBE;
                    end
                end
                PROBE: begin
                    if (lo == hi) begin
                        found_q <= 1'b0;
                        state   <= DONE;
                    end else begin
                        mid          <= mid_c;
                        fetch_addr_q <= WORDLIST_BASE + (24'(mid_c) << 2);
                        fetch_q      <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
`ifdef LOOKUP_TIMEOUT_EN
                    if (tmo_hit) begin
                        fetch_q <= 1'b0;
                        found_q <= 1'b0;
                        state   <= DONE;
                    end else
`endif
                    if (bus.fetch_grant) begin
                        fetch_q <= 1'b0;
                        state   <= RECV;
                    end
                end
                RECV: begin
`ifdef LOOKUP_TIMEOUT_EN
                    if (tmo_hit) begin
                        found_q <= 1'b0;
                        state   <= DONE;
                    end else
`endif
                    if (asm_full) begin
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (entry_key == guess_q) begin
                        found_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        if (guess_q < entry_key) begin
                            hi <= mid;
                        end else begin
                            lo <= mid + IDX_W'(1);
                        end
                        state <= PROBE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dict_lookup_sequencer.sv
// Directed + randomized lookups against an 8-entry word list (keys 10..80) served by a modelled arbiter/flash.
module tb_dict_lookup_sequencer;
    import dict_lookup_sequencer_pkg::*;

    localparam logic [23:0] BASE = 24'h010000;
    localparam int          N    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dict_lookup_sequencer_if bus();

    dict_lookup_sequencer #(
        .WORDLIST_BASE (BASE),
        .WORD_COUNT    (N)
`ifdef LOOKUP_TIMEOUT_EN
        ,
        .TIMEOUT       (50)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [23:0] addr_q[$];
    int          arb_unstable  = 0;
    int          arb_stall_cnt = 0;
    bit          arb_busy      = 1'b0;
    bit          hold_grant    = 1'b0;
    int          byte_limit    = 4;
    int          extra_bytes   = 0;
    bit          spurious      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arbiter + flash: grants 3..40 cycles after seeing fetch, then streams the entry bytes.
    initial begin : arbiter
        logic [23:0] a;
        logic [24:0] k;
        logic [31:0] w;
        int          d;
        int          idx;
        int          nb;
        bus.fetch_grant = 1'b0;
        bus.rd_valid    = 1'b0;
        bus.rd_data     = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.fetch === 1'b1 && !hold_grant && !rst) begin
                arb_busy = 1'b1;
                a = bus.fetch_addr;
                addr_q.push_back(a);
                d = $urandom_range(3, 40);
                repeat (d - 1) begin
                    @(negedge clk);
                    if (!(bus.fetch === 1'b1 && bus.fetch_addr === a)) arb_unstable++;
                end
                bus.fetch_grant = 1'b1;
                @(negedge clk);
                bus.fetch_grant = 1'b0;
                if (bus.fetch !== 1'b0) arb_unstable++;
                idx = int'((a - BASE) >> 2);
                k   = (idx >= 0 && idx < N) ? 25'(10 * (idx + 1)) : 25'h1FFFFFF;
                w   = {7'($urandom), k};
                nb  = (byte_limit < 4) ? byte_limit : 4 + extra_bytes;
                for (int i = 0; i < nb; i++) begin
                    if (i < 4) repeat ($urandom_range(0, 2)) @(negedge clk);
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = (i < 4) ? w[31 - 8*i -: 8] : 8'($urandom);
                    @(negedge clk);
                    bus.rd_valid = 1'b0;
                end
                if (byte_limit < 4) arb_stall_cnt++;
                arb_busy = 1'b0;
            end
        end
    end

    task automatic run_lookup(input logic [24:0] g, input string tag);
        bit          ef;
        bit          seen;
        int          lo;
        int          hi;
        int          m;
        int          n0;
        int          cyc;
        logic [23:0] ea[$];
        ef = 1'b0;
        for (int i = 0; i < N; i++) if (10 * (i + 1) == int'(g)) ef = 1'b1;
        lo = 0;
        hi = N;
        while (lo < hi) begin
            m = (lo + hi) / 2;
            ea.push_back(BASE + 24'(4 * m));
            if (10 * (m + 1) == int'(g)) break;
            else if (int'(g) < 10 * (m + 1)) hi = m;
            else lo = m + 1;
        end
        cyc = 0;
        while (arb_busy && cyc < 500) begin @(negedge clk); cyc++; end
        n0 = addr_q.size();
        bus.guess = g;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_found_clr"}, bus.found, 0);
        check({tag, "_tmo_clr"}, bus.timeout_err, 0);
        seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (bus.done === 1'b1) begin seen = 1'b1; break; end
            if (spurious && $urandom_range(0, 3) == 0) begin
                bus.start = 1'b1;
                bus.guess = 25'($urandom);
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_found"}, bus.found, ef);
            check({tag, "_busy_at_done"}, bus.busy, 0);
            check({tag, "_tmo"}, bus.timeout_err, 0);
            check({tag, "_probes"}, addr_q.size() - n0, ea.size());
            if (addr_q.size() - n0 == ea.size()) begin
                for (int i = 0; i < ea.size(); i++) begin
                    check($sformatf("%s_addr%0d", tag, i), addr_q[n0 + i], ea[i]);
                    check($sformatf("%s_range%0d", tag, i), addr_q[n0 + i] < BASE + 24'(4 * N), 1);
                end
            end
            // start during the done cycle must be ignored
            bus.start = 1'b1;
            bus.guess = 25'($urandom);
            @(negedge clk);
            bus.start = 1'b0;
            check({tag, "_done_pulse"}, bus.done, 0);
            check({tag, "_idle_after"}, bus.busy, 0);
            check({tag, "_found_hold"}, bus.found, ef);
        end
        check({tag, "_fetch_hs"}, arb_unstable, 0);
    endtask

    initial begin : stim
        int          n0;
        int          cyc;
        int          s0;
        int          dn;
        logic [24:0] g;
        bus.start = 1'b0;
        bus.guess = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_found", bus.found, 0);
        check("rst_tmo", bus.timeout_err, 0);
        check("rst_fetch", bus.fetch, 0);
        check("rst_fetch_addr", bus.fetch_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        n0 = addr_q.size();
        run_lookup(25'd40, "g40");
        check("g40_seq_cnt", addr_q.size() - n0, 3);
        if (addr_q.size() - n0 == 3) begin
            check("g40_seq0", addr_q[n0],     24'h010010);
            check("g40_seq1", addr_q[n0 + 1], 24'h010008);
            check("g40_seq2", addr_q[n0 + 2], 24'h01000C);
        end
        run_lookup(25'd5, "g5");
        run_lookup(25'd80, "g80");
        run_lookup(25'd10, "g10");
        run_lookup(25'd85, "g85");
        run_lookup(25'h1FFFFFF, "gbad");

        extra_bytes = 18;
        spurious    = 1'b1;
        run_lookup(25'd30, "x30");
        run_lookup(25'd35, "x35");
        run_lookup(25'd70, "x70");

        for (int r = 0; r < 10; r++) begin
            g = ($urandom_range(0, 1) == 1) ? 25'(10 * $urandom_range(1, 8)) : 25'($urandom_range(0, 90));
            extra_bytes = ($urandom_range(0, 1) == 1) ? 18 : 0;
            spurious    = $urandom_range(0, 1) == 1;
            run_lookup(g, $sformatf("rnd%0d", r));
        end

        // reset in RECV with two bytes collected
        extra_bytes = 0;
        spurious    = 1'b0;
        cyc = 0;
        while (arb_busy && cyc < 500) begin @(negedge clk); cyc++; end
        byte_limit = 2;
        s0 = arb_stall_cnt;
        bus.guess = 25'd40;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (arb_stall_cnt == s0 && cyc < 500) begin @(negedge clk); cyc++; end
        check("rstmid_stalled", arb_stall_cnt - s0, 1);
        check("rstmid_pre_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_fetch", bus.fetch, 0);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_done", bus.done, 0);
        rst = 1'b0;
        byte_limit = 4;
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
        end
        check("rstmid_no_done", dn, 0);
        run_lookup(25'd60, "post_rst");

`ifdef LOOKUP_TIMEOUT_EN
        hold_grant = 1'b1;
        bus.guess = 25'd40;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.fetch !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        check("tmo_fetch_seen", bus.fetch, 1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        check("tmo_latency", cyc, 50);
        check("tmo_found", bus.found, 0);
        check("tmo_err", bus.timeout_err, 1);
        check("tmo_fetch_drop", bus.fetch, 0);
        @(negedge clk);
        check("tmo_err_hold", bus.timeout_err, 1);
        hold_grant = 1'b0;
        run_lookup(25'd30, "post_tmo");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
